// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient controller: drains the FIR, then swaps shadow into active.
// Optional FIR_COEFF_READBACK_EN adds a registered read port on the active bank.
module fir_coeff_ctrl #(
  parameter int N            = 8,
  parameter int COEFF_WIDTH  = 16,
  parameter int DRAIN_CYCLES = 2,
  localparam int AW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [AW-1:0]              cfg_rd_addr,
  output logic [COEFF_WIDTH-1:0]     cfg_rd_data,
`endif
  input  logic                       cfg_wr_en,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [COEFF_WIDTH-1:0]     cfg_data,
  input  logic                       cfg_commit,
  output logic                       cfg_busy,
  output logic                       cfg_err,
  input  logic                       cfg_err_clr,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic                       fir_valid_in,
  output logic                       fir_clr,
  output logic [N*COEFF_WIDTH-1:0]   coeff_bus,
  output logic                       swap_done
);

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  state_t                 state, state_next;
  logic [DW-1:0]          drain_cnt, drain_cnt_next;
  logic                   run;
  logic                   shadow_we;
  logic                   swap_en;
  logic                   err_set;
  logic [COEFF_WIDTH-1:0] shadow [N];
  logic [COEFF_WIDTH-1:0] active [N];

  // Symmetric lowpass loaded into both banks on reset.
  function automatic logic [COEFF_WIDTH-1:0] default_tap(input int k);
    int v;
    case (k)
      0, 7:    v = 1638;
      1, 6:    v = 3277;
      2, 5:    v = 4915;
      3, 4:    v = 6554;
      default: v = 0;
    endcase
    return COEFF_WIDTH'(v);
  endfunction

  // run holds src_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      run       <= 1'b0;
      swap_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      run       <= 1'b1;
      swap_done <= (state == SWAP);
      cfg_err   <= err_set | (cfg_err & ~cfg_err_clr);
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      IDLE: begin
        if (cfg_commit) begin
          state_next     = DRAIN;
          drain_cnt_next = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = SWAP;
        end else begin
          drain_cnt_next = drain_cnt - 1'b1;
        end
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    src_ready    = 1'b0;
    fir_valid_in = 1'b0;
    cfg_busy     = 1'b0;
    fir_clr      = 1'b0;
    shadow_we    = 1'b0;
    swap_en      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        src_ready    = run;
        fir_valid_in = run & src_valid;
        shadow_we    = cfg_wr_en;
      end
      DRAIN: begin
        cfg_busy = 1'b1;
        err_set  = cfg_wr_en | cfg_commit;
      end
      SWAP: begin
        cfg_busy = 1'b1;
        fir_clr  = 1'b1;
        swap_en  = 1'b1;
        err_set  = cfg_wr_en | cfg_commit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) shadow[k] <= default_tap(k);
    end else if (shadow_we) begin
      shadow[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) active[k] <= default_tap(k);
    end else if (swap_en) begin
      active <= shadow;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bus
      assign coeff_bus[gi*COEFF_WIDTH +: COEFF_WIDTH] = active[gi];
    end
  endgenerate

`ifdef FIR_COEFF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rd_data <= '0;
    end else begin
      cfg_rd_data <= active[cfg_rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl at default parameters (N=8, 16-bit taps, 2 drain cycles).
module tb_fir_coeff_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_wr_en = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [15:0]  cfg_data = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_busy;
  logic         cfg_err;
  logic         cfg_err_clr = 1'b0;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic         fir_valid_in;
  logic         fir_clr;
  logic [127:0] coeff_bus;
  logic         swap_done;
`ifdef FIR_COEFF_READBACK_EN
  logic [2:0]   cfg_rd_addr = '0;
  logic [15:0]  cfg_rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int n_busy, n_clr, n_done, n_novalid, clr_idx, done_idx;
  logic [15:0] exp_tap [8];

  fir_coeff_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FIR_COEFF_READBACK_EN
    .cfg_rd_addr  (cfg_rd_addr),
    .cfg_rd_data  (cfg_rd_data),
`endif
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .cfg_busy     (cfg_busy),
    .cfg_err      (cfg_err),
    .cfg_err_clr  (cfg_err_clr),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .fir_valid_in (fir_valid_in),
    .fir_clr      (fir_clr),
    .coeff_bus    (coeff_bus),
    .swap_done    (swap_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] exp_bus();
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = exp_tap[k];
    return r;
  endfunction

  task automatic set_defaults();
    exp_tap = '{16'd1638, 16'd3277, 16'd4915, 16'd6554,
                16'd6554, 16'd4915, 16'd3277, 16'd1638};
  endtask

  // Samples n cycles starting at the current sample point, tallying handshake outputs.
  task automatic window(input int n);
    n_busy = 0; n_clr = 0; n_done = 0; n_novalid = 0; clr_idx = -1; done_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (cfg_busy) n_busy++;
      if (fir_clr) begin n_clr++; clr_idx = i; end
      if (swap_done) begin n_done++; done_idx = i; end
      if (!fir_valid_in) n_novalid++;
      step();
    end
  endtask

  initial begin
    set_defaults();
    src_valid = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_fir_clr", fir_clr, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_fir_valid", fir_valid_in, 0);
    chk("rst_bus", coeff_bus, exp_bus());
`ifdef FIR_COEFF_READBACK_EN
    chk("rst_rd_data", cfg_rd_data, 0);
`endif
    src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rel_src_ready", src_ready, 1);
    chk("rel_busy", cfg_busy, 0);
    chk("rel_err", cfg_err, 0);
    chk("rel_bus", coeff_bus, exp_bus());

    // Tap 3 <- -1000 with src_valid held high across the commit.
    src_valid = 1'b1;
    cfg_wr_en = 1'b1; cfg_addr = 3'd3; cfg_data = 16'hFC18;
    step();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("a_busy_t1", cfg_busy, 1);
    chk("a_ready_t1", src_ready, 0);
    window(8);
    chk("a_busy_cycles", n_busy, 4);
    chk("a_clr_pulses", n_clr, 1);
    chk("a_clr_idx", clr_idx, 3);
    chk("a_done_pulses", n_done, 1);
    chk("a_done_idx", done_idx, 4);
    chk("a_novalid_cycles", n_novalid, 4);
    chk("a_valid_resumes", fir_valid_in, 1);
    exp_tap[3] = 16'hFC18;
    chk("a_bus", coeff_bus, exp_bus());
    chk("a_err", cfg_err, 0);
    src_valid = 1'b0;

    // Write and commit together: the write is part of the swap.
    cfg_wr_en = 1'b1; cfg_addr = 3'd6; cfg_data = 16'd777; cfg_commit = 1'b1;
    step();
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    window(8);
    chk("b_busy_cycles", n_busy, 4);
    chk("b_done_pulses", n_done, 1);
    exp_tap[6] = 16'd777;
    chk("b_bus", coeff_bus, exp_bus());

    // Swap with identical banks still drains and clears.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    window(8);
    chk("b_same_clr", n_clr, 1);
    chk("b_same_busy", n_busy, 4);
    chk("b_same_bus", coeff_bus, exp_bus());

    // Write during DRAIN and commit during SWAP are dropped and flag an error.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    cfg_wr_en = 1'b1; cfg_addr = 3'd5; cfg_data = 16'd100;
    step();
    cfg_wr_en = 1'b0;
    chk("c_err_after_wr", cfg_err, 1);
    step();
    chk("c_in_swap", fir_clr, 1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("c_swap_done", swap_done, 1);
    chk("c_idle_busy", cfg_busy, 0);
    step();
    step();
    chk("c_commit_ignored", cfg_busy, 0);
    chk("c_err_sticky", cfg_err, 1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    window(8);
    chk("c_shadow5_kept", coeff_bus, exp_bus());
    chk("c_err_still", cfg_err, 1);

    // New error and clear in the same cycle keep the flag set.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 3'd2; cfg_data = 16'd5; cfg_err_clr = 1'b1;
    step();
    cfg_wr_en = 1'b0; cfg_err_clr = 1'b0;
    chk("c_set_beats_clr", cfg_err, 1);
    window(6);
    cfg_err_clr = 1'b1;
    step();
    cfg_err_clr = 1'b0;
    chk("c_err_cleared", cfg_err, 0);
    chk("c_bus_after_clr", coeff_bus, exp_bus());

    // Reset in the second DRAIN cycle aborts the swap.
    cfg_wr_en = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd500;
    step();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    chk("d_in_drain", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("d_rst_busy", cfg_busy, 0);
    chk("d_rst_ready", src_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("d_rel_ready", src_ready, 1);
    window(8);
    chk("d_no_swap_done", n_done, 0);
    chk("d_no_busy", n_busy, 0);
    set_defaults();
    chk("d_tap0", coeff_bus[15:0], 16'd1638);
    chk("d_bus", coeff_bus, exp_bus());

`ifdef FIR_COEFF_READBACK_EN
    cfg_wr_en = 1'b1; cfg_addr = 3'd7; cfg_data = 16'd1234;
    step();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    window(8);
    cfg_rd_addr = 3'd7;
    step();
    chk("e_rd_data", cfg_rd_data, 16'd1234);
    cfg_rd_addr = 3'd1;
    step();
    chk("e_rd_data_tap1", cfg_rd_data, 16'd3277);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 8, tap count; COEFF_WIDTH, default 16, signed Q1.15 coefficient width; DRAIN_CYCLES, default 2, FIR valid latency drained before a swap.
REQ-002 Clock and reset SHALL be `clk  in  1`, the single clock with all logic on its rising edge, and `rst_n  in  1`, an asynchronous active-low reset.
REQ-003 Ports SHALL be:
- `cfg_wr_en  in  1`: write shadow coefficient.
- `cfg_addr  in  clog2(N)`: shadow tap index.
- `cfg_data  in  COEFF_WIDTH`: signed coefficient value.
- `cfg_commit  in  1`: request shadow-to-active swap.
- `cfg_busy  out  1`: high in DRAIN and SWAP.
- `cfg_err  out  1`: sticky error flag.
- `cfg_err_clr  in  1`: clear cfg_err.
- `src_valid  in  1`: upstream sample valid.
- `src_ready  out  1`: upstream may present samples.
- `fir_valid_in  out  1`: gated valid to the FIR.
- `fir_clr  out  1`: one-cycle synchronous clear of the FIR shift register.
- `coeff_bus  out  N*COEFF_WIDTH`: active bank; tap k at [k*COEFF_WIDTH +: COEFF_WIDTH].
- `swap_done  out  1`: one-cycle pulse after a swap.

Function
REQ-004 The block SHALL hold two coefficient banks, shadow and active; coeff_bus SHALL always drive the active bank.
REQ-005 The FSM SHALL have exactly three states: IDLE, DRAIN and SWAP.
REQ-006 In IDLE:
- src_ready=1 and fir_valid_in=src_valid.
- cfg_wr_en=1 writes cfg_data into shadow[cfg_addr] at the clock edge.
REQ-007 In IDLE, cfg_commit=1 SHALL move the FSM to DRAIN and load a drain counter with DRAIN_CYCLES.
REQ-008 In DRAIN:
- src_ready=0 and fir_valid_in=0.
- The counter decrements once per cycle.
- At count 0 the FSM moves to SWAP, so DRAIN lasts DRAIN_CYCLES+1 cycles.
REQ-009 SWAP SHALL last one cycle, with all three effects at its end:
- The active bank is copied from the shadow bank.
- fir_clr=1 during SWAP.
- The FSM returns to IDLE with swap_done=1 for that first IDLE cycle.
REQ-010 Commit-to-new-coefficients latency SHALL be DRAIN_CYCLES+2 cycles, i.e. 4 cycles at defaults.
REQ-011 Simultaneous cfg_wr_en and cfg_commit in IDLE: the write SHALL land in shadow and be included in the swap.
REQ-012 In DRAIN or SWAP, cfg_wr_en SHALL be dropped, leaving shadow unchanged, and SHALL set cfg_err.
REQ-013 In DRAIN or SWAP, cfg_commit SHALL be ignored and SHALL set cfg_err.
REQ-014 cfg_err SHALL stay set until cfg_err_clr; a new error and cfg_err_clr in the same cycle SHALL leave cfg_err=1.
REQ-015 src_valid while src_ready=0 SHALL NOT reach the FIR; upstream SHALL hold the sample until src_ready=1.
REQ-016 A swap with identical shadow and active contents SHALL still perform the full DRAIN/SWAP sequence, including fir_clr.

Reset
REQ-017 Assertion of rst_n=0 SHALL immediately set:
- state=IDLE and drain counter=0.
- cfg_busy=0, cfg_err=0, fir_clr=0, swap_done=0, fir_valid_in=0.
REQ-018 Reset SHALL load both banks with the default lowpass set 1638, 3277, 4915, 6554, 6554, 4915, 3277, 1638 (taps 0..7 at N=8).
REQ-019 Reset during DRAIN or SWAP SHALL abort the swap; the active bank SHALL hold the defaults after release.
REQ-020 After rst_n rises, src_ready SHALL be 1 on the first clock edge.

Configuration
REQ-021 With FIR_COEFF_READBACK_EN defined, the block SHALL add ports `cfg_rd_addr  in  clog2(N)` and `cfg_rd_data  out  COEFF_WIDTH`.
- cfg_rd_data returns active[cfg_rd_addr] registered, with 1-cycle latency.
- cfg_rd_data resets to 0.
REQ-022 Without FIR_COEFF_READBACK_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Reset release -> coeff_bus equals the default set, src_ready=1, cfg_busy=0, cfg_err=0.
REQ-024 Write shadow[3]=-1000, then commit -> cfg_busy=1 for 4 cycles, fir_clr pulses once, swap_done pulses, and coeff_bus tap 3 reads -1000 while the other taps are unchanged.
REQ-025 src_valid held at 1 across a commit -> fir_valid_in=0 for exactly 4 cycles and no sample is lost once src_ready returns to 1.
REQ-026 Write addr 5 = 100 during DRAIN, then cfg_commit during SWAP -> shadow[5] is unchanged, cfg_err=1, and cfg_err stays 1 until cfg_err_clr.
REQ-027 rst_n pulsed low in the second DRAIN cycle after shadow[0]=500 -> coeff_bus tap 0=1638, state IDLE, swap_done never asserted.
REQ-028 With FIR_COEFF_READBACK_EN defined, after swapping tap 7 to 1234, cfg_rd_addr=7 -> cfg_rd_data=1234 one cycle later.
